// File: rtl/display_scan_if.sv
// Display scan interface: bundles the scan controller's control inputs and its
// anode-decoder / segment-decoder outputs.
//   en, digits[15:0], dp_in[3:0], lzb       : panel -> controller
//   H, Sel1, Sel2, bcd_out[3:0], dp_out,
//   frame_tick                               : controller -> decoders
// master: the panel side that drives the control inputs.
// slave : the scan controller.
interface display_scan_if;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        lzb;
    logic        H;
    logic        Sel1;
    logic        Sel2;
    logic [3:0]  bcd_out;
    logic        dp_out;
    logic        frame_tick;

    modport master (
        output en, digits, dp_in, lzb,
        input  H, Sel1, Sel2, bcd_out, dp_out, frame_tick
    );

    modport slave (
        input  en, digits, dp_in, lzb,
        output H, Sel1, Sel2, bcd_out, dp_out, frame_tick
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit 7-segment display.
// Each digit slot is SCAN_DIV cycles: BLANK_CYC cycles with the anode decoder
// disabled (anti-ghosting), then the remainder with the digit shown. Digits,
// decimal points and the leading-zero-blank flag are snapshotted once per frame
// so a frame never mixes old and new values.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : display_scan_if.slave (en, digits, dp_in, lzb in;
//           H, Sel1, Sel2, bcd_out, dp_out, frame_tick out)
module display_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    display_scan_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      snap_q, snap_d;
    logic [3:0]       dp_snap_q, dp_snap_d;
    logic             lzb_snap_q, lzb_snap_d;
    logic             tick_q, tick_d;

    // A slot is blanked when blanking is on and it and every slot to its left
    // hold zero; the rightmost slot always shows so "0" remains visible.
    function automatic logic lead_blank(input logic [15:0] d, input logic lz,
                                        input logic [1:0] i);
        logic r;
        r = 1'b0;
        if (lz) begin
            case (i)
                2'd0:    r = (d[15:12] == 4'd0);
                2'd1:    r = (d[15:8] == 8'd0);
                2'd2:    r = (d[15:4] == 12'd0);
                default: r = 1'b0;
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            snap_q     <= '0;
            dp_snap_q  <= '0;
            lzb_snap_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            dp_snap_q  <= dp_snap_d;
            lzb_snap_q <= lzb_snap_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        dp_snap_d  = dp_snap_q;
        lzb_snap_d = lzb_snap_q;
        tick_d     = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = BLANK;
                    cnt_d      = '0;
                    idx_d      = '0;
                    snap_d     = bus.digits;
                    dp_snap_d  = bus.dp_in;
                    lzb_snap_d = bus.lzb;
                    tick_d     = 1'b1;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        // Frame boundary: new snapshot lands with slot 0's first blank cycle.
                        if (idx_q == 2'd3) begin
                            snap_d     = bus.digits;
                            dp_snap_d  = bus.dp_in;
                            lzb_snap_d = bus.lzb;
                            tick_d     = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    logic [3:0] bcd_sel;
    logic       dp_sel;

    always_comb begin
        bcd_sel = 4'd0;
        dp_sel  = 1'b0;
        case (idx_q)
            2'd0:    begin bcd_sel = snap_q[15:12]; dp_sel = dp_snap_q[3]; end
            2'd1:    begin bcd_sel = snap_q[11:8];  dp_sel = dp_snap_q[2]; end
            2'd2:    begin bcd_sel = snap_q[7:4];   dp_sel = dp_snap_q[1]; end
            default: begin bcd_sel = snap_q[3:0];   dp_sel = dp_snap_q[0]; end
        endcase
    end

    assign bus.H          = (state_q == SHOW) && !lead_blank(snap_q, lzb_snap_q, idx_q);
    assign bus.Sel1       = idx_q[1];
    assign bus.Sel2       = idx_q[0];
    assign bus.bcd_out    = bcd_sel;
    assign bus.dp_out     = dp_sel;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2. The reference model
// tracks the position inside a 32-cycle frame since enable and derives slot,
// blank/show and leading-zero blanking arithmetically from that position.
module tb_display_scan_ctrl;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * SD;

    logic clk;
    logic rst_n;
    display_scan_if bus ();

    display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .CNT_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_active;
    int          m_pos;
    logic [15:0] m_snap;
    logic [3:0]  m_dp;
    logic        m_lzb;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_snap   = '0;
        m_dp     = '0;
        m_lzb    = 1'b0;
    endtask

    function automatic logic model_blank(input int slot);
        if (!m_lzb || slot == 3) return 1'b0;
        for (int j = 0; j <= slot; j++)
            if (m_snap[4*(3-j) +: 4] != 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_outputs();
        int   slot;
        logic exp_h;
        slot  = m_active ? (m_pos / SD) : 0;
        exp_h = m_active && ((m_pos % SD) >= BC) && !model_blank(slot);
        chk("H", 16'(bus.H), 16'(exp_h));
        chk("sel", 16'({bus.Sel1, bus.Sel2}), 16'(slot));
        chk("bcd", 16'(bus.bcd_out), 16'(m_snap[4*(3-slot) +: 4]));
        chk("dp", 16'(bus.dp_out), 16'(m_dp[3-slot]));
        chk("tick", 16'(bus.frame_tick), 16'(m_active && m_pos == 0));
    endtask

    task automatic step();
        logic        en_s;
        logic [15:0] dg_s;
        logic [3:0]  dp_s;
        logic        lz_s;
        en_s = bus.en;
        dg_s = bus.digits;
        dp_s = bus.dp_in;
        lz_s = bus.lzb;
        @(posedge clk);
        if (!en_s) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else begin
            if (!m_active) begin
                m_active = 1'b1;
                m_pos    = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
            if (m_pos == 0) begin
                m_snap = dg_s;
                m_dp   = dp_s;
                m_lzb  = lz_s;
            end
        end
        #1;
        check_outputs();
    endtask

    // Advance until the model sits at frame position p (bounded).
    task automatic run_to(input int p);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (m_active && m_pos == p) return;
            step();
        end
        chk("run_to_timeout", 16'(m_pos), 16'(p));
    endtask

    task automatic run_frames_with(input logic [15:0] d);
        bus.digits = d;
        repeat (2 * FRAME) step();
    endtask

    initial begin
        model_reset();
        rst_n      = 1'b0;
        bus.en     = 1'b0;
        bus.digits = '0;
        bus.dp_in  = '0;
        bus.lzb    = 1'b0;
        #3;
        check_outputs();

        // 1: release reset with en=0, outputs stay dark
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step();

        // 2: plain scan of 1234
        bus.digits = 16'h1234;
        bus.en     = 1'b1;
        repeat (2 * FRAME) step();

        // 3: change digits mid-frame (slot 1 SHOW)
        run_to(SD + 3);
        bus.digits = 16'h5678;
        repeat (FRAME + 24) step();

        // 4: leading-zero blanking
        bus.lzb = 1'b1;
        run_frames_with(16'h0045);
        run_frames_with(16'h0000);
        run_frames_with(16'h0405);

        // 5: disable in slot 2 SHOW, then re-enable with new digits
        run_to(2 * SD + 4);
        bus.en = 1'b0;
        step();
        chk("dis_H", 16'(bus.H), 16'd0);
        chk("dis_sel", 16'({bus.Sel1, bus.Sel2}), 16'd0);
        repeat (3) step();
        bus.digits = 16'h9021;
        bus.en     = 1'b1;
        step();
        chk("reen_tick", 16'(bus.frame_tick), 16'd1);
        chk("reen_bcd", 16'(bus.bcd_out), 16'd9);
        repeat (FRAME) step();

        // 6: decimal point only on slot 1
        bus.lzb    = 1'b0;
        bus.dp_in  = 4'b0100;
        bus.digits = 16'h1234;
        repeat (2 * FRAME) step();

        // async reset mid-SHOW
        run_to(SD + 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_H", 16'(bus.H), 16'd0);
        chk("arst_sel", 16'({bus.Sel1, bus.Sel2}), 16'd0);
        chk("arst_tick", 16'(bus.frame_tick), 16'd0);
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();

        // randomized phase
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 7) == 0) begin
                for (int n = 0; n < 4; n++)
                    bus.digits[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
                bus.dp_in = 4'($urandom);
                bus.lzb   = 1'($urandom);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
